// File: rtl/input_conditioner.sv
// -----------------------------------------------------------------------------
// input_conditioner
//   Front end for the sensor/arm FSM pair. Every raw pad input is brought into
//   the clk domain through a two-flop synchroniser. It is then debounced by its
//   own four-state FSM and counter. The block produces a clean level and
//   one-cycle rise/fall pulses. Channel mapping: ch0 -> C1, ch1 -> C2, ch2 -> I.
//
// Ports
//   clk         in   1     system clock, rising edge
//   rst_n       in   1     asynchronous active-low reset, clears every flop
//   ena         in   1     1 = FSMs/counters advance, 0 = hold (pulses forced 0)
//   raw_in      in   N_CH  asynchronous raw inputs
//   level_out   out  N_CH  debounced level per channel (registered)
//   rise_pulse  out  N_CH  one-cycle pulse on an accepted 0->1 (registered)
//   fall_pulse  out  N_CH  one-cycle pulse on an accepted 1->0 (registered)
// -----------------------------------------------------------------------------
module input_conditioner #(
  parameter int N_CH            = 3,
  parameter int DEBOUNCE_CYCLES = 16   // legal range 1..255
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ena,
  input  logic [N_CH-1:0] raw_in,
  output logic [N_CH-1:0] level_out,
  output logic [N_CH-1:0] rise_pulse,
  output logic [N_CH-1:0] fall_pulse
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // Encoding chosen so that bit 1 of the state equals the debounced level.
  typedef enum logic [1:0] {
    ST_LOW    = 2'b00,
    ST_PEND_H = 2'b01,
    ST_HIGH   = 2'b11,
    ST_PEND_L = 2'b10
  } state_t;

  logic [N_CH-1:0]  r_sync1;
  logic [N_CH-1:0]  r_sync2;
  state_t           r_state     [N_CH];
  state_t           w_state_nxt [N_CH];
  logic [CNT_W-1:0] r_cnt       [N_CH];
  logic [CNT_W-1:0] w_cnt_nxt   [N_CH];
  logic [N_CH-1:0]  w_rise_nxt;
  logic [N_CH-1:0]  w_fall_nxt;
  logic [N_CH-1:0]  w_level_nxt;
  logic [N_CH-1:0]  r_level;
  logic [N_CH-1:0]  r_rise;
  logic [N_CH-1:0]  r_fall;

  // Two-flop synchroniser; it runs whether or not ena is asserted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= {N_CH{1'b0}};
      r_sync2 <= {N_CH{1'b0}};
    end else begin
      r_sync1 <= raw_in;
      r_sync2 <= r_sync1;
    end
  end

  // Per-channel debounce next-state, counter and pulse decode.
  always_comb begin
    w_rise_nxt  = {N_CH{1'b0}};
    w_fall_nxt  = {N_CH{1'b0}};
    w_level_nxt = {N_CH{1'b0}};
    for (int ch = 0; ch < N_CH; ch++) begin
      w_state_nxt[ch] = r_state[ch];
      w_cnt_nxt[ch]   = r_cnt[ch];
      if (ena) begin
        case (r_state[ch])
          ST_LOW: begin
            if (r_sync2[ch]) begin
              w_state_nxt[ch] = ST_PEND_H;
              w_cnt_nxt[ch]   = CNT_ZERO;
            end else begin
              w_state_nxt[ch] = ST_LOW;
            end
          end
          ST_PEND_H: begin
            if (!r_sync2[ch]) begin
              w_state_nxt[ch] = ST_LOW;
              w_cnt_nxt[ch]   = CNT_ZERO;
            end else if (r_cnt[ch] == CNT_MAX) begin
              w_state_nxt[ch] = ST_HIGH;
              w_cnt_nxt[ch]   = CNT_ZERO;
              w_rise_nxt[ch]  = 1'b1;
            end else begin
              w_cnt_nxt[ch]   = r_cnt[ch] + CNT_ONE;
            end
          end
          ST_HIGH: begin
            if (!r_sync2[ch]) begin
              w_state_nxt[ch] = ST_PEND_L;
              w_cnt_nxt[ch]   = CNT_ZERO;
            end else begin
              w_state_nxt[ch] = ST_HIGH;
            end
          end
          ST_PEND_L: begin
            if (r_sync2[ch]) begin
              w_state_nxt[ch] = ST_HIGH;
              w_cnt_nxt[ch]   = CNT_ZERO;
            end else if (r_cnt[ch] == CNT_MAX) begin
              w_state_nxt[ch] = ST_LOW;
              w_cnt_nxt[ch]   = CNT_ZERO;
              w_fall_nxt[ch]  = 1'b1;
            end else begin
              w_cnt_nxt[ch]   = r_cnt[ch] + CNT_ONE;
            end
          end
          default: begin
            w_state_nxt[ch] = ST_LOW;
            w_cnt_nxt[ch]   = CNT_ZERO;
          end
        endcase
      end else begin
        w_state_nxt[ch] = r_state[ch];
        w_cnt_nxt[ch]   = r_cnt[ch];
      end
      w_level_nxt[ch] = w_state_nxt[ch][1];
    end
  end

  // State, counter and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int ch = 0; ch < N_CH; ch++) begin
        r_state[ch] <= ST_LOW;
        r_cnt[ch]   <= CNT_ZERO;
      end
      r_level <= {N_CH{1'b0}};
      r_rise  <= {N_CH{1'b0}};
      r_fall  <= {N_CH{1'b0}};
    end else begin
      for (int ch = 0; ch < N_CH; ch++) begin
        r_state[ch] <= w_state_nxt[ch];
        r_cnt[ch]   <= w_cnt_nxt[ch];
      end
      r_level <= w_level_nxt;
      r_rise  <= w_rise_nxt;
      r_fall  <= w_fall_nxt;
    end
  end

  assign level_out  = r_level;
  assign rise_pulse = r_rise;
  assign fall_pulse = r_fall;

endmodule

// File: tb/tb_input_conditioner.sv
// -----------------------------------------------------------------------------
// tb_input_conditioner
//   Self-checking bench for input_conditioner with DEBOUNCE_CYCLES=4.
//   The reference model keeps two delayed copies of raw_in. It counts the
//   consecutive enabled samples in which the synchronised input differs from
//   the accepted level. A change is accepted once that run reaches
//   DEBOUNCE_CYCLES+1 samples.
// -----------------------------------------------------------------------------
module tb_input_conditioner;

  localparam int NCH = 3;
  localparam int DB  = 4;

  logic           clk;
  logic           rst_n;
  logic           ena;
  logic [NCH-1:0] raw;
  logic [NCH-1:0] level_out;
  logic [NCH-1:0] rise_pulse;
  logic [NCH-1:0] fall_pulse;

  int n_checks;
  int n_fail;

  // reference model state
  logic [NCH-1:0] m_s1, m_s2, m_level, m_rise, m_fall;
  int             m_run [NCH];

  input_conditioner #(.N_CH(NCH), .DEBOUNCE_CYCLES(DB)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .raw_in     (raw),
    .level_out  (level_out),
    .rise_pulse (rise_pulse),
    .fall_pulse (fall_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_level = '0; m_rise = '0; m_fall = '0;
    for (int c = 0; c < NCH; c++) m_run[c] = 0;
  endtask

  // Advance one clock edge and update the model, then return at the negedge.
  task automatic step();
    @(posedge clk);
    if (rst_n) begin
      for (int c = 0; c < NCH; c++) begin
        m_rise[c] = 1'b0;
        m_fall[c] = 1'b0;
        if (ena) begin
          if (m_s2[c] != m_level[c]) begin
            m_run[c]++;
            if (m_run[c] == DB + 1) begin
              m_level[c] = ~m_level[c];
              if (m_level[c]) m_rise[c] = 1'b1;
              else            m_fall[c] = 1'b1;
              m_run[c] = 0;
            end
          end else begin
            m_run[c] = 0;
          end
        end
      end
      m_s2 = m_s1;
      m_s1 = raw;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    raw = 3'b111; ena = 1'b1; rst_n = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if ({level_out, rise_pulse, fall_pulse} !== 9'b0) begin
      n_fail++;
      $display("FAIL reset_async got=%b exp=%b", {level_out, rise_pulse, fall_pulse}, 9'b0);
    end
    repeat (3) step();
    n_checks++;
    if ({level_out, rise_pulse, fall_pulse} !== 9'b0) begin
      n_fail++;
      $display("FAIL reset_hold got=%b exp=%b", {level_out, rise_pulse, fall_pulse}, 9'b0);
    end
    rst_n = 1'b1; raw = 3'b001;
    for (int k = 0; k < 9; k++) begin
      step();
      n_checks++;
      if ({level_out, rise_pulse, fall_pulse} !== {m_level, m_rise, m_fall}) begin
        n_fail++;
        $display("FAIL reset_rise_model k=%0d got=%b exp=%b", k,
                 {level_out, rise_pulse, fall_pulse}, {m_level, m_rise, m_fall});
      end
      if (k == 6) begin
        n_checks++;
        if (level_out !== 3'b001 || rise_pulse !== 3'b001) begin
          n_fail++;
          $display("FAIL first_rise_edge6 got lvl=%b rise=%b exp lvl=001 rise=001", level_out, rise_pulse);
        end
      end
      if (k == 7) begin
        n_checks++;
        if (rise_pulse !== 3'b000) begin
          n_fail++;
          $display("FAIL first_rise_drop got=%b exp=000", rise_pulse);
        end
      end
    end
  endtask

  task automatic test_glitch();
    raw = 3'b011;
    for (int k = 0; k < 12; k++) begin
      step();
      if (k == 2) raw = 3'b001;
      n_checks++;
      if ({level_out, rise_pulse, fall_pulse} !== {m_level, m_rise, m_fall} ||
          level_out[1] !== 1'b0 || rise_pulse[1] !== 1'b0 || fall_pulse[1] !== 1'b0) begin
        n_fail++;
        $display("FAIL glitch k=%0d got=%b exp=%b", k,
                 {level_out, rise_pulse, fall_pulse}, {m_level, m_rise, m_fall});
      end
    end
  endtask

  task automatic test_fall();
    raw = 3'b000;
    for (int k = 0; k < 9; k++) begin
      step();
      n_checks++;
      if ({level_out, rise_pulse, fall_pulse} !== {m_level, m_rise, m_fall}) begin
        n_fail++;
        $display("FAIL fall_model k=%0d got=%b exp=%b", k,
                 {level_out, rise_pulse, fall_pulse}, {m_level, m_rise, m_fall});
      end
      if (k == 6) begin
        n_checks++;
        if (fall_pulse !== 3'b001 || level_out !== 3'b000) begin
          n_fail++;
          $display("FAIL fall_edge6 got fall=%b lvl=%b exp fall=001 lvl=000", fall_pulse, level_out);
        end
      end
    end
  endtask

  task automatic test_simultaneous();
    raw = 3'b111;
    for (int k = 0; k < 8; k++) begin
      step();
      if (k == 6) begin
        n_checks++;
        if (rise_pulse !== 3'b111 || level_out !== 3'b111) begin
          n_fail++;
          $display("FAIL simul_rise got rise=%b lvl=%b exp rise=111 lvl=111", rise_pulse, level_out);
        end
      end
    end
    raw = 3'b000;
    for (int k = 0; k < 10; k++) begin
      step();
      n_checks++;
      if ({level_out, rise_pulse, fall_pulse} !== {m_level, m_rise, m_fall}) begin
        n_fail++;
        $display("FAIL simul_fall k=%0d got=%b exp=%b", k,
                 {level_out, rise_pulse, fall_pulse}, {m_level, m_rise, m_fall});
      end
    end
  endtask

  task automatic test_ena_hold();
    raw = 3'b100;
    repeat (4) step();               // ch2 now pending with cnt=1
    ena = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      n_checks++;
      if (rise_pulse !== 3'b000 || level_out !== 3'b000) begin
        n_fail++;
        $display("FAIL ena_hold k=%0d got rise=%b lvl=%b exp 000/000", k, rise_pulse, level_out);
      end
    end
    ena = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      step();
      n_checks++;
      if (rise_pulse[2] !== (k == 3) || rise_pulse !== m_rise) begin
        n_fail++;
        $display("FAIL ena_resume k=%0d got rise=%b exp=%b", k, rise_pulse, m_rise);
      end
    end
    raw = 3'b000;
    repeat (10) step();
  endtask

  task automatic test_reset_mid();
    raw = 3'b010;
    repeat (8) step();               // ch1 accepted high
    raw = 3'b011;
    repeat (5) step();               // ch0 pending with cnt=2
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if ({level_out, rise_pulse, fall_pulse} !== 9'b0) begin
      n_fail++;
      $display("FAIL reset_mid_async got=%b exp=%b", {level_out, rise_pulse, fall_pulse}, 9'b0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 9; k++) begin
      step();
      n_checks++;
      if ({level_out, rise_pulse, fall_pulse} !== {m_level, m_rise, m_fall} ||
          (k == 6 && rise_pulse !== 3'b011)) begin
        n_fail++;
        $display("FAIL reset_mid_rise k=%0d got=%b exp=%b", k,
                 {level_out, rise_pulse, fall_pulse}, {m_level, m_rise, m_fall});
      end
    end
  endtask

  task automatic test_random();
    int hold;
    hold = 0;
    for (int k = 0; k < 600; k++) begin
      if (hold == 0) begin
        raw  = 3'($urandom_range(0, 7));
        hold = $urandom_range(1, 9);
      end else begin
        hold--;
      end
      ena = ($urandom_range(0, 9) != 0);
      step();
      n_checks++;
      if ({level_out, rise_pulse, fall_pulse} !== {m_level, m_rise, m_fall}) begin
        n_fail++;
        $display("FAIL random k=%0d got=%b exp=%b", k,
                 {level_out, rise_pulse, fall_pulse}, {m_level, m_rise, m_fall});
      end
    end
    ena = 1'b1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b1;
    ena      = 1'b1;
    raw      = 3'b000;
    model_reset();
    @(negedge clk);
    test_reset();
    test_glitch();
    test_fall();
    test_simultaneous();
    test_ena_hold();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
